red_pitaya_fads_sort_gate: RTL and testbench

//  Downstream of the FADS threshold comparator. Turns its raw in-window level (det_i) into one timed sort pulse per droplet.

---
 rtl/red_pitaya_fads_pkg.sv | 22 ++
 rtl/red_pitaya_fads_sort_regs.sv | 95 +++++++++
 rtl/red_pitaya_fads_sort_gate.sv | 191 +++++++++++++++++++
 tb/tb_red_pitaya_fads_sort_gate.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// rtl/red_pitaya_fads_pkg.sv - FADS sort gate state encoding and register offsets
package red_pitaya_fads_pkg;

    // Encoding is visible to software through the status register.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_DELAY   = 3'd2,
        ST_FIRE    = 3'd3,
        ST_LOCKOUT = 3'd4
    } fads_state_t;

    localparam logic [19:0] ADDR_CTRL        = 20'h00;
    localparam logic [19:0] ADDR_MIN_WIDTH   = 20'h04;
    localparam logic [19:0] ADDR_DELAY       = 20'h08;
    localparam logic [19:0] ADDR_PULSE_LEN   = 20'h0C;
    localparam logic [19:0] ADDR_LOCKOUT     = 20'h10;
    localparam logic [19:0] ADDR_STATUS      = 20'h14;
    localparam logic [19:0] ADDR_DROPLET_CNT = 20'h18;
    localparam logic [19:0] ADDR_SORT_CNT    = 20'h1C;

endpackage

// File: rtl/red_pitaya_fads_sort_regs.sv
// rtl/red_pitaya_fads_sort_regs.sv - FADS sort gate bus decode, config registers and readback
//  Ports: i_clk/i_rst (sync, active high); i_sys_* bus request; o_sys_rdata/o_sys_ack/o_sys_err
//  response (registered, one cycle after request); o_enable/o_stat_clear and the four timing
//  registers to the FSM; i_state/i_det/i_droplet_cnt/i_sort_cnt for readback.
module red_pitaya_fads_sort_regs
    import red_pitaya_fads_pkg::*;
#(
    parameter int CNT_W  = 24,
    parameter int STAT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_sys_addr,
    input  logic [31:0]       i_sys_wdata,
    input  logic              i_sys_wen,
    input  logic              i_sys_ren,
    output logic [31:0]       o_sys_rdata,
    output logic              o_sys_ack,
    output logic              o_sys_err,
    output logic              o_enable,
    output logic              o_stat_clear,
    output logic [CNT_W-1:0]  o_min_width,
    output logic [CNT_W-1:0]  o_delay,
    output logic [CNT_W-1:0]  o_pulse_len,
    output logic [CNT_W-1:0]  o_lockout,
    input  fads_state_t       i_state,
    input  logic              i_det,
    input  logic [STAT_W-1:0] i_droplet_cnt,
    input  logic [STAT_W-1:0] i_sort_cnt
);

    logic              r_enable;
    logic [CNT_W-1:0]  r_min_width, r_delay, r_pulse_len, r_lockout;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic [31:0]       w_rdata;
    logic [19:0]       w_addr;
    logic              w_unused;

    assign w_addr   = i_sys_addr[19:0];
    assign w_unused = ^{i_sys_addr[31:20], i_sys_wdata[31:CNT_W]};

    // stat_clear is a pulse on the write itself so it never reads back as 1.
    assign o_stat_clear = i_sys_wen && (w_addr == ADDR_CTRL) && i_sys_wdata[1];

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_CTRL:        w_rdata = {31'd0, r_enable};
            ADDR_MIN_WIDTH:   w_rdata = 32'(r_min_width);
            ADDR_DELAY:       w_rdata = 32'(r_delay);
            ADDR_PULSE_LEN:   w_rdata = 32'(r_pulse_len);
            ADDR_LOCKOUT:     w_rdata = 32'(r_lockout);
            ADDR_STATUS:      w_rdata = {28'd0, i_det, i_state};
            ADDR_DROPLET_CNT: w_rdata = 32'(i_droplet_cnt);
            ADDR_SORT_CNT:    w_rdata = 32'(i_sort_cnt);
            default:          w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_enable    <= 1'b0;
            r_min_width <= '0;
            r_delay     <= '0;
            r_pulse_len <= '0;
            r_lockout   <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_ack   <= i_sys_wen | i_sys_ren;
            r_rdata <= i_sys_ren ? w_rdata : '0;
            if (i_sys_wen) begin
                case (w_addr)
                    ADDR_CTRL:      r_enable    <= i_sys_wdata[0];
                    ADDR_MIN_WIDTH: r_min_width <= i_sys_wdata[CNT_W-1:0];
                    ADDR_DELAY:     r_delay     <= i_sys_wdata[CNT_W-1:0];
                    ADDR_PULSE_LEN: r_pulse_len <= i_sys_wdata[CNT_W-1:0];
                    ADDR_LOCKOUT:   r_lockout   <= i_sys_wdata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign o_enable    = r_enable;
    assign o_min_width = r_min_width;
    assign o_delay     = r_delay;
    assign o_pulse_len = r_pulse_len;
    assign o_lockout   = r_lockout;
    assign o_sys_rdata = r_rdata;
    assign o_sys_ack   = r_ack;
    assign o_sys_err   = 1'b0;

endmodule

// File: rtl/red_pitaya_fads_sort_gate.sv
// rtl/red_pitaya_fads_sort_gate.sv - FADS sort gate: glitch filter, travel delay, trigger pulse, lockout
//  Ports: adc_clk_i/adc_rst_i (sync, active high); det_i comparator level; sort_trig_o ASG trigger;
//  busy_o (state != IDLE); sys_* system bus slave (sys_sel ignored, sys_err always 0).
//  Optional: `define FADS_SORT_STATS_EN builds the droplet/sort statistics counters.
module red_pitaya_fads_sort_gate
    import red_pitaya_fads_pkg::*;
#(
    parameter int CNT_W  = 24,
    parameter int STAT_W = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        det_i,
    output logic        sort_trig_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    fads_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_det_prev;
    logic [CNT_W-1:0]  r_delay, r_pulse_len, r_lockout;
    logic              w_snap, w_drop_inc, w_sort_inc;
    logic              w_enable, w_stat_clear;
    logic [CNT_W-1:0]  w_min_width, w_delay, w_pulse_len, w_lockout;
    logic [STAT_W-1:0] w_droplet_cnt, w_sort_cnt;
    logic              w_unused;

    assign w_unused = ^sys_sel;

    red_pitaya_fads_sort_regs #(.CNT_W(CNT_W), .STAT_W(STAT_W)) u_regs (
        .i_clk         (adc_clk_i),
        .i_rst         (adc_rst_i),
        .i_sys_addr    (sys_addr),
        .i_sys_wdata   (sys_wdata),
        .i_sys_wen     (sys_wen),
        .i_sys_ren     (sys_ren),
        .o_sys_rdata   (sys_rdata),
        .o_sys_ack     (sys_ack),
        .o_sys_err     (sys_err),
        .o_enable      (w_enable),
        .o_stat_clear  (w_stat_clear),
        .o_min_width   (w_min_width),
        .o_delay       (w_delay),
        .o_pulse_len   (w_pulse_len),
        .o_lockout     (w_lockout),
        .i_state       (r_state),
        .i_det         (det_i),
        .i_droplet_cnt (w_droplet_cnt),
        .i_sort_cnt    (w_sort_cnt)
    );

    // One shared down-counter: each phase loads (length-1) and leaves when it reads 0.
    // Zero-length phases are skipped by falling through to the next non-zero phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_snap      = 1'b0;
        w_drop_inc  = 1'b0;
        w_sort_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (det_i && !r_det_prev) begin
                    w_state_nxt = ST_QUALIFY;
                    w_snap      = 1'b1;
                    // The rising-edge sample already counts as one high sample.
                    w_cnt_nxt   = (w_min_width == '0) ? '0 : (w_min_width - CNT_ONE);
                end
            end
            ST_QUALIFY: begin
                if (r_cnt == '0) begin
                    w_drop_inc = 1'b1;
                    if (r_delay != '0) begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = r_delay - CNT_ONE;
                    end else if (r_pulse_len != '0) begin
                        w_state_nxt = ST_FIRE;
                        w_cnt_nxt   = r_pulse_len - CNT_ONE;
                        w_sort_inc  = 1'b1;
                    end else if (r_lockout != '0) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_cnt_nxt   = r_lockout - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!det_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_DELAY: begin
                if (r_cnt == '0) begin
                    if (r_pulse_len != '0) begin
                        w_state_nxt = ST_FIRE;
                        w_cnt_nxt   = r_pulse_len - CNT_ONE;
                        w_sort_inc  = 1'b1;
                    end else if (r_lockout != '0) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_cnt_nxt   = r_lockout - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_FIRE: begin
                if (r_cnt == '0) begin
                    if (r_lockout != '0) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_cnt_nxt   = r_lockout - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_LOCKOUT: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt - CNT_ONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!w_enable) begin
            w_state_nxt = ST_IDLE;
            w_snap      = 1'b0;
            w_drop_inc  = 1'b0;
            w_sort_inc  = 1'b0;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_det_prev  <= 1'b0;
            r_delay     <= '0;
            r_pulse_len <= '0;
            r_lockout   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_det_prev <= det_i;
            // Snapshot so bus writes mid-droplet only affect the next droplet.
            if (w_snap) begin
                r_delay     <= w_delay;
                r_pulse_len <= w_pulse_len;
                r_lockout   <= w_lockout;
            end
        end
    end

`ifdef FADS_SORT_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    logic [STAT_W-1:0] r_droplet_cnt, r_sort_cnt;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i || w_stat_clear) begin
            r_droplet_cnt <= '0;
            r_sort_cnt    <= '0;
        end else begin
            if (w_drop_inc) r_droplet_cnt <= r_droplet_cnt + STAT_ONE;
            if (w_sort_inc) r_sort_cnt    <= r_sort_cnt + STAT_ONE;
        end
    end

    assign w_droplet_cnt = r_droplet_cnt;
    assign w_sort_cnt    = r_sort_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_stat_clear ^ w_drop_inc ^ w_sort_inc;
    assign w_droplet_cnt  = '0;
    assign w_sort_cnt     = '0;
`endif

    assign sort_trig_o = (r_state == ST_FIRE);
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_red_pitaya_fads_sort_gate.sv
// tb/tb_red_pitaya_fads_sort_gate.sv - directed self-checking bench for red_pitaya_fads_sort_gate
module tb_red_pitaya_fads_sort_gate;

    logic        adc_clk_i = 1'b0;
    logic        adc_rst_i = 1'b1;
    logic        det_i     = 1'b0;
    logic        sort_trig_o, busy_o;
    logic [31:0] sys_addr  = '0;
    logic [31:0] sys_wdata = '0;
    logic [3:0]  sys_sel   = 4'hF;
    logic        sys_wen   = 1'b0;
    logic        sys_ren   = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err, sys_ack;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] rd_val;

    always #5 adc_clk_i = ~adc_clk_i;

    red_pitaya_fads_sort_gate dut (
        .adc_clk_i   (adc_clk_i),
        .adc_rst_i   (adc_rst_i),
        .det_i       (det_i),
        .sort_trig_o (sort_trig_o),
        .busy_o      (busy_o),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    task automatic tick();
        @(posedge adc_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        tick();
        sys_wen   = 1'b0;
        chk("wr_ack", {31'd0, sys_ack}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a;
        sys_ren  = 1'b1;
        tick();
        sys_ren  = 1'b0;
        d        = sys_rdata;
        chk("rd_ack", {31'd0, sys_ack}, 32'd1);
        chk("rd_err", {31'd0, sys_err}, 32'd0);
    endtask

    function automatic logic [31:0] st(input int n);
`ifdef FADS_SORT_STATS_EN
        return n;
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic cfg(input int mw, input int dl, input int pl, input int lk);
        wr(32'h04, mw);
        wr(32'h08, dl);
        wr(32'h0C, pl);
        wr(32'h10, lk);
    endtask

    // Test 3 detector pattern, indexed by cycles after the first rising edge.
    function automatic logic det3(input int k);
        return (k <= 5) || (k == 9) || (k == 10) || (k == 16) ||
               (k >= 25 && k <= 38) || (k >= 40 && k <= 45);
    endfunction

    initial begin
        // Reset state
        tick(); tick();
        adc_rst_i = 1'b0;
        chk("rst_trig", {31'd0, sort_trig_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ack",  {31'd0, sys_ack}, 32'd0);
        rd(32'h00, rd_val); chk("rst_ctrl", rd_val, 32'd0);
        rd(32'h14, rd_val); chk("rst_status", rd_val, 32'd0);

        // Bus readback and unmapped read
        cfg(4, 10, 5, 20);
        rd(32'h04, rd_val); chk("rb_min_width", rd_val, 32'd4);
        rd(32'h08, rd_val); chk("rb_delay", rd_val, 32'd10);
        rd(32'h0C, rd_val); chk("rb_pulse_len", rd_val, 32'd5);
        rd(32'h10, rd_val); chk("rb_lockout", rd_val, 32'd20);
        rd(32'h40, rd_val); chk("rb_unmapped", rd_val, 32'd0);
        wr(32'h00, 32'd1);
        rd(32'h00, rd_val); chk("rb_ctrl", rd_val, 32'd1);

        // Test 1: qualified droplet, pulse at E0+14..E0+18, idle at E0+39
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 40; k++) begin
            chk($sformatf("t1_trig_%0d", k), {31'd0, sort_trig_o}, {31'd0, (k >= 14 && k <= 18)});
            chk($sformatf("t1_busy_%0d", k), {31'd0, busy_o}, {31'd0, (k <= 38)});
            det_i = (k + 1 <= 5);
            tick();
        end
        rd(32'h18, rd_val); chk("t1_droplet_cnt", rd_val, st(1));
        rd(32'h1C, rd_val); chk("t1_sort_cnt", rd_val, st(1));

        // Test 2: glitch of 3 samples rejected
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("t2_trig_%0d", k), {31'd0, sort_trig_o}, 32'd0);
            chk($sformatf("t2_busy_%0d", k), {31'd0, busy_o}, {31'd0, (k < 3)});
            det_i = (k + 1 <= 2);
            tick();
        end
        rd(32'h18, rd_val); chk("t2_droplet_cnt", rd_val, st(1));

        // Test 3: edges during DELAY/FIRE/LOCKOUT ignored, edge just after lockout fires again
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 80; k++) begin
            chk($sformatf("t3_trig_%0d", k), {31'd0, sort_trig_o},
                {31'd0, ((k >= 14 && k <= 18) || (k >= 54 && k <= 58))});
            chk($sformatf("t3_busy_%0d", k), {31'd0, busy_o},
                {31'd0, ((k <= 38) || (k >= 40 && k <= 78))});
            det_i = det3(k + 1);
            tick();
        end
        rd(32'h18, rd_val); chk("t3_droplet_cnt", rd_val, st(3));
        rd(32'h1C, rd_val); chk("t3_sort_cnt", rd_val, st(3));

        // Test 4: zero corners, single-cycle pulse at E0+1
        cfg(0, 0, 1, 0);
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 3; k++) begin
            chk($sformatf("t4a_trig_%0d", k), {31'd0, sort_trig_o}, {31'd0, (k == 1)});
            chk($sformatf("t4a_busy_%0d", k), {31'd0, busy_o}, {31'd0, (k <= 1)});
            det_i = 1'b0;
            tick();
        end
        wr(32'h0C, 32'd0);
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 3; k++) begin
            chk($sformatf("t4b_trig_%0d", k), {31'd0, sort_trig_o}, 32'd0);
            chk($sformatf("t4b_busy_%0d", k), {31'd0, busy_o}, {31'd0, (k == 0)});
            det_i = 1'b0;
            tick();
        end
        rd(32'h18, rd_val); chk("t4_droplet_cnt", rd_val, st(5));
        rd(32'h1C, rd_val); chk("t4_sort_cnt", rd_val, st(4));

        // Test 5a: enable cleared during FIRE
        cfg(4, 10, 5, 20);
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 14; k++) begin
            det_i = (k + 1 <= 5);
            tick();
        end
        chk("t5_trig_fire", {31'd0, sort_trig_o}, 32'd1);
        sys_addr  = 32'h00;
        sys_wdata = 32'd0;
        sys_wen   = 1'b1;
        tick();
        sys_wen   = 1'b0;
        chk("t5_trig_wr_edge", {31'd0, sort_trig_o}, 32'd1);
        tick();
        chk("t5_trig_off", {31'd0, sort_trig_o}, 32'd0);
        chk("t5_busy_off", {31'd0, busy_o}, 32'd0);
        rd(32'h14, rd_val); chk("t5_status_idle", rd_val, 32'd0);
        rd(32'h18, rd_val); chk("t5_droplet_cnt", rd_val, st(6));
        rd(32'h1C, rd_val); chk("t5_sort_cnt", rd_val, st(5));

        // Test 6: stat_clear (self-clearing) with enable set
        wr(32'h00, 32'd3);
        rd(32'h18, rd_val); chk("clr_droplet_cnt", rd_val, 32'd0);
        rd(32'h1C, rd_val); chk("clr_sort_cnt", rd_val, 32'd0);
        rd(32'h00, rd_val); chk("clr_ctrl", rd_val, 32'd1);

        // Test 5b: reset mid-DELAY
        det_i = 1'b1;
        tick();
        for (int k = 0; k <= 5; k++) begin
            det_i = (k + 1 <= 5);
            tick();
        end
        chk("t5b_busy_delay", {31'd0, busy_o}, 32'd1);
        rd(32'h14, rd_val); chk("t5b_status_delay", rd_val, 32'd2);
        adc_rst_i = 1'b1;
        tick();
        adc_rst_i = 1'b0;
        chk("t5b_busy_rst", {31'd0, busy_o}, 32'd0);
        chk("t5b_trig_rst", {31'd0, sort_trig_o}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t5b_trig_%0d", k), {31'd0, sort_trig_o}, 32'd0);
            tick();
        end
        rd(32'h00, rd_val); chk("t5b_ctrl", rd_val, 32'd0);
        rd(32'h04, rd_val); chk("t5b_min_width", rd_val, 32'd0);
        rd(32'h0C, rd_val); chk("t5b_pulse_len", rd_val, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
